// File: rtl/decoder_scan_active_low.sv
// ============================================================================
// Module  : decoder_scan_active_low
// Brief   : Registered active-low one-hot decoder, direct or auto-scan,
//           with break-before-make blanking between selects.
// Revision: 1.0
// ============================================================================
`default_nettype none

module decoder_scan_active_low #(
    parameter int SEL_W        = 3,
    parameter int DWELL_W      = 16,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable_n,
    input  logic                 mode,
    input  logic [SEL_W-1:0]     x,
    input  logic [DWELL_W-1:0]   dwell,
    input  logic [SEL_W-1:0]     last,
    output logic [2**SEL_W-1:0]  y,
    output logic [SEL_W-1:0]     sel_idx,
    output logic                 active,
    output logic                 frame_pulse
);

    localparam int N = 2**SEL_W;
    // A zero-cycle blank never reaches S_BLANK, but the counter still needs one bit.
    localparam int c_bcnt_w = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [c_bcnt_w-1:0] c_bcnt_last =
        c_bcnt_w'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_BLANK  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [SEL_W-1:0]      sel_idx_q, sel_idx_d;
    logic [N-1:0]          y_q, y_d;
    logic                  active_q, active_d;
    logic                  frame_pulse_q, frame_pulse_d;
    logic [DWELL_W-1:0]    cnt_q, cnt_d;
    logic [DWELL_W-1:0]    dwell_q, dwell_d;
    logic                  mode_ent_q, mode_ent_d;
    logic [c_bcnt_w-1:0]   bcnt_q, bcnt_d;

    logic [SEL_W-1:0]      w_scan_nxt;
    logic [SEL_W-1:0]      w_nxt;
    logic                  w_enter;
    logic [SEL_W-1:0]      w_enter_idx;
    logic                  w_leave;
    logic [N-1:0]          w_onehot;

    always_comb begin
        state_d       = state_q;
        sel_idx_d     = sel_idx_q;
        cnt_d         = cnt_q;
        dwell_d       = dwell_q;
        mode_ent_d    = mode_ent_q;
        bcnt_d        = bcnt_q;
        frame_pulse_d = 1'b0;
        w_enter       = 1'b0;
        w_leave       = 1'b0;

        // >= rather than == so a lowered 'last' wraps instead of running to N-1.
        w_scan_nxt  = (sel_idx_q >= last) ? '0 : sel_idx_q + SEL_W'(1);
        w_nxt       = mode ? w_scan_nxt : x;
        w_enter_idx = w_nxt;

        if (enable_n) begin
            state_d   = S_IDLE;
            sel_idx_d = '0;
            cnt_d     = '0;
            bcnt_d    = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    w_enter     = 1'b1;
                    w_enter_idx = mode ? '0 : x;
                end
                S_ACTIVE: begin
                    w_leave = (mode != mode_ent_q) ||
                              (mode_ent_q ? (cnt_q == dwell_q) : (x != sel_idx_q));
                    if (w_leave) begin
                        if (BLANK_CYCLES > 0) begin
                            state_d = S_BLANK;
                            bcnt_d  = '0;
                        end else begin
                            w_enter = 1'b1;
                        end
                    end else if (mode_ent_q) begin
                        cnt_d = cnt_q + DWELL_W'(1);
                    end
                end
                S_BLANK: begin
                    if (bcnt_q == c_bcnt_last) begin
                        w_enter = 1'b1;
                    end else begin
                        bcnt_d = bcnt_q + c_bcnt_w'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (w_enter) begin
            state_d       = S_ACTIVE;
            sel_idx_d     = w_enter_idx;
            cnt_d         = '0;
            dwell_d       = dwell;
            mode_ent_d    = mode;
            frame_pulse_d = mode && (w_enter_idx == '0);
        end

        w_onehot = {{(N-1){1'b0}}, 1'b1} << sel_idx_d;
        active_d = (state_d == S_ACTIVE);
        y_d      = active_d ? ~w_onehot : '1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            sel_idx_q     <= '0;
            y_q           <= '1;
            active_q      <= 1'b0;
            frame_pulse_q <= 1'b0;
            cnt_q         <= '0;
            dwell_q       <= '0;
            mode_ent_q    <= 1'b0;
            bcnt_q        <= '0;
        end else begin
            state_q       <= state_d;
            sel_idx_q     <= sel_idx_d;
            y_q           <= y_d;
            active_q      <= active_d;
            frame_pulse_q <= frame_pulse_d;
            cnt_q         <= cnt_d;
            dwell_q       <= dwell_d;
            mode_ent_q    <= mode_ent_d;
            bcnt_q        <= bcnt_d;
        end
    end

    assign y           = y_q;
    assign sel_idx     = sel_idx_q;
    assign active      = active_q;
    assign frame_pulse = frame_pulse_q;

endmodule

`default_nettype wire
